// File: rtl/ir_hit_scorer.sv
// ir_hit_scorer: debounces IR target lines, queues hits and accumulates a saturating 4-digit BCD score.
// Ports:
//   clock, reset           system clock, synchronous active-high reset
//   ir_in_i                raw asynchronous IR receiver lines, one per target channel
//   game_active_i          new hit events are accepted only while high
//   clear_score_i          one-cycle pulse: zero the score and drop pending hits
//   double_points_i        power-up flag, sampled when a hit is dequeued
//   hit_pulse_o            one-cycle strobe per dequeued hit
//   hit_channel_o          channel index of the last dequeued hit
//   score_*_o              BCD score digits for the VGA display
//   saturated_o            high while the score is 9999
module ir_hit_scorer #(
    parameter int         NUM_CH     = 16,
    parameter int         DEBOUNCE   = 50000,
    parameter int         CNT_W      = 16,
    parameter logic [7:0] POINTS_BCD = 8'h10,
    parameter bit         ACTIVE_LOW = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ir_in_i,
    input  logic              game_active_i,
    input  logic              clear_score_i,
    input  logic              double_points_i,
    output logic              hit_pulse_o,
    output logic [3:0]        hit_channel_o,
    output logic [3:0]        score_ones_o,
    output logic [3:0]        score_tens_o,
    output logic [3:0]        score_hundreds_o,
    output logic [3:0]        score_thousands_o,
    output logic              saturated_o
);
    typedef enum logic [1:0] {IDLE, ADD, ADD2} state_e;

    localparam logic [NUM_CH-1:0] RAW_IDLE = ACTIVE_LOW ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE - 1);
    localparam logic [15:0]       PTS      = {8'h00, POINTS_BCD};

    logic [NUM_CH-1:0] sync1_q, sync2_q, deb_q, deb_d, deb_prev_q, mask_q, mask_d;
    logic [NUM_CH-1:0] lvl, rise, svc;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    state_e            state_q, state_d;
    logic              dbl_q, dbl_d, hit_pulse_q, hit_pulse_d;
    logic [3:0]        hit_channel_q, hit_channel_d, sel;
    logic [15:0]       score_q, score_d;

    // Digit-serial BCD add of the point value; a carry out of the top digit clamps to 9999.
    function automatic logic [15:0] bcd_add(input logic [15:0] a);
        logic [4:0]  d;
        logic        c;
        logic [15:0] r;
        c = 1'b0;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            d = {1'b0, a[4*k +: 4]} + {1'b0, PTS[4*k +: 4]} + {4'd0, c};
            c = d > 5'd9;
            r[4*k +: 4] = c ? d[3:0] - 4'd10 : d[3:0];
        end
        return c ? 16'h9999 : r;
    endfunction

    assign lvl  = ACTIVE_LOW ? ~sync2_q : sync2_q;
    assign rise = deb_q & ~deb_prev_q;

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = '0;
            if (lvl[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) deb_d[i] = lvl[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Lowest-index pending channel wins.
    always_comb begin
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (mask_q[i]) sel = 4'(i);
    end

    always_comb begin
        state_d       = state_q;
        dbl_d         = dbl_q;
        hit_pulse_d   = 1'b0;
        hit_channel_d = hit_channel_q;
        score_d       = score_q;
        svc           = '0;
        case (state_q)
            IDLE: if (|mask_q) begin
                svc           = NUM_CH'(1) << sel;
                hit_channel_d = sel;
                hit_pulse_d   = 1'b1;
                dbl_d         = double_points_i;
                state_d       = ADD;
            end
            ADD: begin
                score_d = bcd_add(score_q);
                state_d = dbl_q ? ADD2 : IDLE;
            end
            ADD2: begin
                score_d = bcd_add(score_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A new event re-arms a bit even if it is being serviced this cycle.
        mask_d = (mask_q & ~svc) | (game_active_i ? rise : '0);
        if (clear_score_i) begin
            score_d     = '0;
            mask_d      = '0;
            state_d     = IDLE;
            hit_pulse_d = 1'b0;
            dbl_d       = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q       <= RAW_IDLE;
            sync2_q       <= RAW_IDLE;
            deb_q         <= '0;
            deb_prev_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
            mask_q        <= '0;
            state_q       <= IDLE;
            dbl_q         <= 1'b0;
            hit_pulse_q   <= 1'b0;
            hit_channel_q <= '0;
            score_q       <= '0;
        end else begin
            sync1_q       <= ir_in_i;
            sync2_q       <= sync1_q;
            deb_q         <= deb_d;
            deb_prev_q    <= deb_q;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
            mask_q        <= mask_d;
            state_q       <= state_d;
            dbl_q         <= dbl_d;
            hit_pulse_q   <= hit_pulse_d;
            hit_channel_q <= hit_channel_d;
            score_q       <= score_d;
        end
    end

    assign hit_pulse_o       = hit_pulse_q;
    assign hit_channel_o     = hit_channel_q;
    assign score_ones_o      = score_q[3:0];
    assign score_tens_o      = score_q[7:4];
    assign score_hundreds_o  = score_q[11:8];
    assign score_thousands_o = score_q[15:12];
    assign saturated_o       = score_q == 16'h9999;
endmodule
